// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a length-prefixed byte image into instruction memory
module program_loader #(
    parameter int INS_WIDTH  = 26,
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [INS_WIDTH-1:0]  mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] words_loaded
);
    localparam int BYTES    = (INS_WIDTH + 7) / 8;
    localparam int BIW      = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TOP_BITS = INS_WIDTH - 8 * (BYTES - 1);
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, WORD, WRITE, DONE, ERR
    } state_t;

    state_t state, state_next;

    logic [15:0]            len;
    logic [15:0]            word_idx;
    logic [BIW-1:0]         byte_idx;
    logic [8*(BYTES-1)-1:0] word_buf;
    logic [31:0]            idle_cnt;
    logic                   accept;
    logic                   loading;
    logic                   load_start;
    logic                   timeout_hit;
    logic                   last_word;

    // Decode per-state outputs and the handshake/timeout conditions
    always_comb begin
        loading     = (state == LEN_LO) || (state == LEN_HI) || (state == WORD);
        rx_ready    = loading;
        mem_we      = (state == WRITE);
        done        = (state == DONE);
        cpu_hold    = (state != IDLE);
        accept      = loading && rx_valid;
        load_start  = ((state == IDLE) || (state == ERR)) && start;
        // A byte arriving on the expiry edge wins over the timeout
        timeout_hit = (TIMEOUT != 0) && loading && !accept && (idle_cnt == 32'(TIMEOUT - 1));
        last_word   = (word_idx == len - 16'd1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = LEN_LO;
            LEN_LO: if (accept) state_next = LEN_HI;
                    else if (timeout_hit) state_next = ERR;
            LEN_HI: if (accept) state_next = ({rx_data, len[7:0]} == 16'd0) ? DONE : WORD;
                    else if (timeout_hit) state_next = ERR;
            WORD:   if (accept && (byte_idx == LAST_BYTE)) state_next = WRITE;
                    else if (timeout_hit) state_next = ERR;
            WRITE:  state_next = last_word ? DONE : WORD;
            DONE:   state_next = IDLE;
            ERR:    if (start) state_next = LEN_LO;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, write registers, counters and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len          <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            idle_cnt     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            if (accept || load_start || (state == WRITE))
                idle_cnt <= '0;
            else if (loading)
                idle_cnt <= idle_cnt + 32'd1;

            if (timeout_hit)
                error <= 1'b1;

            if (accept) begin
                case (state)
                    LEN_LO: len[7:0]  <= rx_data;
                    LEN_HI: len[15:8] <= rx_data;
                    WORD: begin
                        byte_idx <= (byte_idx == LAST_BYTE) ? '0 : byte_idx + 1'b1;
                        if (byte_idx == LAST_BYTE) begin
                            // Top byte contributes only its low bits; the rest is padding
                            mem_wdata <= {rx_data[TOP_BITS-1:0], word_buf};
                            mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_idx);
                        end else begin
                            word_buf <= {rx_data, word_buf[8*(BYTES-1)-1:8]};
                        end
                    end
                    default: ;
                endcase
            end

            if (state == WRITE) begin
                words_loaded <= words_loaded + 1'b1;
                word_idx     <= word_idx + 16'd1;
            end

            if (load_start) begin
                error        <= 1'b0;
                words_loaded <= '0;
                byte_idx     <= '0;
                word_idx     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader at two base addresses
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;

    logic        rx_ready [2];
    logic        mem_we [2];
    logic [15:0] mem_addr [2];
    logic [25:0] mem_wdata [2];
    logic        cpu_hold [2];
    logic        done [2];
    logic        error [2];
    logic [15:0] words_loaded [2];

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_a0[$], exp_a1[$];
    logic [25:0] exp_d0[$], exp_d1[$];
    logic [15:0] exp_w0[$], exp_w1[$];

    program_loader #(.INS_WIDTH(26), .ADDR_WIDTH(16), .BASE_ADDR(0), .TIMEOUT(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .cpu_hold(cpu_hold[0]), .done(done[0]),
        .error(error[0]), .words_loaded(words_loaded[0])
    );

    program_loader #(.INS_WIDTH(26), .ADDR_WIDTH(16), .BASE_ADDR('hFFFF), .TIMEOUT(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .cpu_hold(cpu_hold[1]), .done(done[1]),
        .error(error[1]), .words_loaded(words_loaded[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor for the base-0 loader: every write and done pulse must match the scoreboard
    always @(negedge clk) begin
        if (mem_we[0]) begin
            if (exp_a0.size() == 0) begin
                checks++; errors++;
                $display("FAIL write0_unexpected: got addr %0h data %0h required no write", mem_addr[0], mem_wdata[0]);
            end else begin
                chk("write0_addr", 32'(mem_addr[0]), 32'(exp_a0.pop_front()));
                chk("write0_data", 32'(mem_wdata[0]), 32'(exp_d0.pop_front()));
            end
        end
        if (done[0]) begin
            if (exp_w0.size() == 0) begin
                checks++; errors++;
                $display("FAIL done0_unexpected: got done required none");
            end else begin
                chk("done0_words", 32'(words_loaded[0]), 32'(exp_w0.pop_front()));
            end
        end
    end

    // Monitor for the base-0xFFFF loader
    always @(negedge clk) begin
        if (mem_we[1]) begin
            if (exp_a1.size() == 0) begin
                checks++; errors++;
                $display("FAIL write1_unexpected: got addr %0h data %0h required no write", mem_addr[1], mem_wdata[1]);
            end else begin
                chk("write1_addr", 32'(mem_addr[1]), 32'(exp_a1.pop_front()));
                chk("write1_data", 32'(mem_wdata[1]), 32'(exp_d1.pop_front()));
            end
        end
        if (done[1]) begin
            if (exp_w1.size() == 0) begin
                checks++; errors++;
                $display("FAIL done1_unexpected: got done required none");
            end else begin
                chk("done1_words", 32'(words_loaded[1]), 32'(exp_w1.pop_front()));
            end
        end
    end

    task automatic expect_write(input logic [15:0] idx, input logic [25:0] data);
        exp_a0.push_back(idx);
        exp_a1.push_back(16'(idx + 16'hFFFF));
        exp_d0.push_back(data);
        exp_d1.push_back(data);
    endtask

    task automatic expect_done(input logic [15:0] wl);
        exp_w0.push_back(wl);
        exp_w1.push_back(wl);
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_rx_ready"}, 32'(rx_ready[d]), 32'd0);
            chk({tag, "_mem_we"}, 32'(mem_we[d]), 32'd0);
            chk({tag, "_mem_addr"}, 32'(mem_addr[d]), 32'd0);
            chk({tag, "_mem_wdata"}, 32'(mem_wdata[d]), 32'd0);
            chk({tag, "_cpu_hold"}, 32'(cpu_hold[d]), 32'd0);
            chk({tag, "_done"}, 32'(done[d]), 32'd0);
            chk({tag, "_error"}, 32'(error[d]), 32'd0);
            chk({tag, "_words_loaded"}, 32'(words_loaded[d]), 32'd0);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_rx_ready", 32'(rx_ready[0]), 32'd1);
        chk("start_cpu_hold", 32'(cpu_hold[1]), 32'd1);
    endtask

    // Present one byte and hold it until accepted; returns one step after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL send_byte_stall: got rx_ready 0 for %0d cycles required 1", n);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Send one word; returns inside the WRITE cycle
    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [15:0] idx, input logic [25:0] data);
        expect_write(idx, data);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        chk("write_cycle_mem_we", 32'(mem_we[0]), 32'd1);
        chk("write_cycle_rx_ready", 32'(rx_ready[0]), 32'd0);
    endtask

    // Called in the last WRITE cycle: done next cycle, hold released the cycle after
    task automatic finish_load(input logic [15:0] wl);
        @(posedge clk); #1;
        chk("finish_done", 32'(done[0]), 32'd1);
        chk("finish_hold_during_done", 32'(cpu_hold[0]), 32'd1);
        @(posedge clk); #1;
        chk("finish_done_cleared", 32'(done[0]), 32'd0);
        chk("finish_hold_released", 32'(cpu_hold[0]), 32'd0);
        chk("finish_words_loaded0", 32'(words_loaded[0]), 32'(wl));
        chk("finish_words_loaded1", 32'(words_loaded[1]), 32'(wl));
    endtask

    initial begin
        #100000;
        checks++; errors++;
        $display("FAIL watchdog: got no end of stimulus required finish before 100000ns");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-word load; base 0xFFFF loader wraps to 0x0000 on the second word
        expect_done(16'd2);
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(8'h78, 8'h56, 8'h34, 8'h12, 16'd0, 26'h2345678);
        send_word(8'hFF, 8'hEE, 8'hDD, 8'hFF, 16'd1, 26'h3DDEEFF);
        finish_load(16'd2);

        // Empty image: done right after the length, no write
        expect_done(16'd0);
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
        chk("n0_done", 32'(done[0]), 32'd1);
        chk("n0_mem_we", 32'(mem_we[0]), 32'd0);
        @(posedge clk); #1;
        chk("n0_hold_released", 32'(cpu_hold[0]), 32'd0);
        chk("n0_words_loaded", 32'(words_loaded[0]), 32'd0);

        // Backpressure: next byte offered during WRITE waits one cycle
        expect_done(16'd2);
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(8'hAA, 8'hBB, 8'hCC, 8'h01, 16'd0, 26'h1CCBBAA);
        expect_write(16'd1, 26'h0332211);
        rx_data  = 8'h11;
        rx_valid = 1'b1;
        chk("bp_write_rx_ready", 32'(rx_ready[0]), 32'd0);
        @(posedge clk); #1;
        chk("bp_word_rx_ready", 32'(rx_ready[0]), 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("bp_last_mem_we", 32'(mem_we[0]), 32'd1);
        finish_load(16'd2);

        // Timeout after N=1 and two bytes, then recovery via start
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAB);
        send_byte(8'hCD);
        repeat (15) @(posedge clk);
        #1;
        chk("to_error_before", 32'(error[0]), 32'd0);
        chk("to_rx_ready_before", 32'(rx_ready[0]), 32'd1);
        @(posedge clk); #1;
        chk("to_error0", 32'(error[0]), 32'd1);
        chk("to_error1", 32'(error[1]), 32'd1);
        chk("to_cpu_hold", 32'(cpu_hold[0]), 32'd1);
        chk("to_rx_ready", 32'(rx_ready[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("to_error_sticky", 32'(error[0]), 32'd1);
        expect_done(16'd1);
        do_start();
        chk("to_error_cleared", 32'(error[0]), 32'd0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(8'h10, 8'h20, 8'h30, 8'h03, 16'd0, 26'h3302010);
        finish_load(16'd1);

        // Reset after the write to index 3 of a six-word load
        do_start();
        send_byte(8'h06);
        send_byte(8'h00);
        send_word(8'h01, 8'h02, 8'h03, 8'h04, 16'd0, 26'h0030201);
        send_word(8'h05, 8'h06, 8'h07, 8'hFE, 16'd1, 26'h2070605);
        send_word(8'h09, 8'h0A, 8'h0B, 8'hFD, 16'd2, 26'h10B0A09);
        send_word(8'h0D, 8'h0E, 8'h0F, 8'h07, 16'd3, 26'h30F0E0D);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_done(16'd1);
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(8'h01, 8'h00, 8'h00, 8'h00, 16'd0, 26'h0000001);
        finish_load(16'd1);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_writes_left0", 32'(exp_a0.size()), 32'd0);
        chk("sb_writes_left1", 32'(exp_a1.size()), 32'd0);
        chk("sb_dones_left0", 32'(exp_w0.size()), 32'd0);
        chk("sb_dones_left1", 32'(exp_w1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Writes a program image into the processor's 26-bit instruction memory from an external byte stream. It is the write side of the instruction fetch path: the program counter only reads program memory, and this block fills it. It holds the processor (`cpu_hold`) for the whole load so no instruction is fetched from a partially written image. It accepts a 16-bit word count followed by packed instruction bytes, and issues one memory write per assembled instruction.

## Interface
- `INS_WIDTH`, 26: instruction width; bytes per word = ceil(INS_WIDTH/8) = 4.
- `ADDR_WIDTH`, 16: program memory address width.
- `BASE_ADDR`, 0: address of the first written instruction.
- `TIMEOUT`, 1000000: maximum idle cycles between bytes while loading; 0 disables the timeout.

- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle request to begin a load.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the loader accepts a byte this cycle.
- `mem_we` out 1: program memory write strobe, one cycle per instruction.
- `mem_addr` out ADDR_WIDTH: write address.
- `mem_wdata` out INS_WIDTH: write data.
- `cpu_hold` out 1: holds the processor's program counter and register writes.
- `done` out 1: one-cycle pulse when a load completes successfully.
- `error` out 1: sticky timeout flag; cleared by the next accepted `start`.
- `words_loaded` out ADDR_WIDTH: number of instructions written in the current or last load.

## Operation
- States: IDLE, LEN_LO, LEN_HI, WORD, WRITE, DONE, ERR.
- A byte is accepted on a rising edge where `rx_valid && rx_ready`.
- `rx_ready` = 1 only in LEN_LO, LEN_HI and WORD.
- IDLE:
  - `start` -> LEN_LO.
  - Clears `error`, `words_loaded`, the byte index and the word index.
- LEN_LO: an accepted byte becomes N[7:0] -> LEN_HI.
- LEN_HI: an accepted byte becomes N[15:8].
  - If N == 0 -> DONE; else -> WORD.
- WORD: collects 4 bytes, little-endian: word = {b3[1:0], b2, b1, b0}.
  - b3[7:2] is ignored.
  - Acceptance of the 4th byte -> WRITE.
- WRITE: one cycle with `mem_we`=1, `mem_addr`=BASE_ADDR+index (mod 2^ADDR_WIDTH) and `mem_wdata`=the assembled word.
  - `words_loaded` increments on this edge.
  - If index == N-1 -> DONE; else index+1 -> WORD.
- DONE: one cycle with `done`=1 -> IDLE.
- ERR: entered from LEN_LO, LEN_HI or WORD when TIMEOUT consecutive cycles pass with no accepted byte.
  - The idle counter restarts on every accepted byte and on entry to LEN_LO or WORD.
  - In ERR, `error`=1 and `cpu_hold` stays 1, so a partial image never runs.
  - `start` -> LEN_LO and clears `error`.
- `cpu_hold` = 1 in every state except IDLE.
- `start` is ignored in every state except IDLE and ERR.
- `mem_addr` and `mem_wdata` are registered and keep their last value when `mem_we`=0.
- N = 65535 is legal. Address wrap-around past 2^ADDR_WIDTH-1 is silent.

## Timing
- Reset values: state IDLE; every output is 0, including `cpu_hold`, `rx_ready`, `error` and `words_loaded`.
- Reset mid-load aborts immediately. Memory keeps its partial contents, and no `done` is issued.
- `start` sampled at edge t: `rx_ready`=1 and `cpu_hold`=1 from cycle t+1.
- 4th byte of a word accepted at edge t: `mem_we` is high in cycle t+1, and `rx_ready`=0 in that cycle.
- A byte presented during WRITE is held by the source and accepted in cycle t+2 at the earliest.
- Minimum throughput: 5 cycles per instruction.
- Last WRITE in cycle t: `done` in cycle t+1, `cpu_hold` falls at cycle t+2.
- N = 0: LEN_HI byte accepted at edge t gives `done` in cycle t+1, with no `mem_we`.
- Timeout: ERR is entered on the edge at which the idle count reaches TIMEOUT.
- `rx_valid` together with the timeout on the same edge: the byte wins; it is accepted and the counter restarts.

## Test plan
- N=2. Bytes 02 00, then 78 56 34 12, then FF EE DD FF -> writes addr 0 = 0x2345678 and addr 1 = 0x3DDEEFF. Then `done` pulses once, `words_loaded`=2, `cpu_hold` falls 2 cycles after the last write.
- N=0 (bytes 00 00) -> `done` the cycle after the 2nd byte, no `mem_we`, `words_loaded`=0.
- Backpressure: hold `rx_valid`=1 with the next byte during WRITE -> `rx_ready`=0 in that cycle, byte accepted the following cycle, data intact.
- TIMEOUT=16. Send N=1 plus 2 bytes, then go silent -> `error`=1 exactly 16 idle cycles after the last byte, `cpu_hold`=1, `rx_ready`=0. A `start` clears `error` and a full reload succeeds.
- Reset mid-load: `rst_n` low after the write to addr 3 -> all outputs 0 at once, no `done`. A subsequent `start` reloads from addr 0.
- BASE_ADDR=0xFFFF, N=2 -> writes at 0xFFFF then 0x0000, `done` asserted.
